// File: rtl/hardcloud_vec_alu_stream.sv
// Element-wise AXI4-Stream ALU: applies a per-run operation with a constant to every lane,
// counts beats, generates tlast and flags upstream tlast mismatches.
module hardcloud_vec_alu_stream #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_LANE_WIDTH       = 32,
    parameter int C_PIPE_STAGES      = 2,
    parameter int C_XFER_SIZE_WIDTH  = 32
) (
    input  logic                          aclk,
    input  logic                          areset_n,
    input  logic                          ap_start,
    output logic                          ap_done,
    output logic                          ap_idle,
    input  logic [2:0]                    ctrl_mode,
    input  logic [C_LANE_WIDTH-1:0]       ctrl_constant,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic                          err_tlast
);

    localparam int LANES      = C_AXIS_TDATA_WIDTH / C_LANE_WIDTH;
    localparam int BEAT_BYTES = C_AXIS_TDATA_WIDTH / 8;
    localparam int CW         = C_XFER_SIZE_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 total_q, total_d;
    logic [CW-1:0]                 in_cnt_q, in_cnt_d;
    logic                          err_q, err_d;
    logic [2:0]                    mode_q, mode_d;
    logic [C_LANE_WIDTH-1:0]       const_q, const_d;
    logic [C_PIPE_STAGES-1:0]      vld_p_q, vld_p_d;
    logic [C_PIPE_STAGES-1:0]      last_p_q, last_p_d;
    logic [C_AXIS_TDATA_WIDTH-1:0] data_p_q [C_PIPE_STAGES];
    logic [C_AXIS_TDATA_WIDTH-1:0] data_p_d [C_PIPE_STAGES];
    logic [C_AXIS_TDATA_WIDTH-1:0] alu_res;
    logic [CW-1:0]                 total_calc;
    logic                          stall, in_fire, out_fire, in_is_last;

    function automatic logic [C_LANE_WIDTH-1:0] lane_op(
        input logic [2:0]              mode,
        input logic [C_LANE_WIDTH-1:0] x,
        input logic [C_LANE_WIDTH-1:0] c
    );
        logic [C_LANE_WIDTH-1:0] r;
        case (mode)
            3'd0:    r = x + c;
            3'd1:    r = x - c;
            3'd2:    r = x * c;
            3'd3:    r = x & c;
            3'd4:    r = x | c;
            3'd5:    r = x ^ c;
            3'd6:    r = (x > c) ? x : c;
            default: r = (x < c) ? x : c;
        endcase
        return r;
    endfunction

    // Extra bit keeps the ceiling rounding from overflowing near the top of the byte range.
    assign total_calc = (CW'(ctrl_xfer_size_in_bytes) + CW'(BEAT_BYTES - 1)) / CW'(BEAT_BYTES);

    assign stall         = vld_p_q[C_PIPE_STAGES-1] && !m_axis_tready;
    assign s_axis_tready = (state_q == S_RUN) && !stall;
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign out_fire      = m_axis_tvalid && m_axis_tready;
    assign in_is_last    = (in_cnt_q == total_q - CW'(1));

    assign m_axis_tvalid = vld_p_q[C_PIPE_STAGES-1];
    assign m_axis_tlast  = last_p_q[C_PIPE_STAGES-1];
    assign m_axis_tdata  = data_p_q[C_PIPE_STAGES-1];
    assign ap_done       = (state_q == S_DONE);
    assign ap_idle       = (state_q == S_IDLE);
    assign err_tlast     = err_q;

    always_comb begin
        alu_res = '0;
        for (int l = 0; l < LANES; l++) begin
            alu_res[l*C_LANE_WIDTH +: C_LANE_WIDTH] =
                lane_op(mode_q, s_axis_tdata[l*C_LANE_WIDTH +: C_LANE_WIDTH], const_q);
        end
    end

    // Whole chain advances together; tlast rides alongside each beat from acceptance.
    always_comb begin
        vld_p_d  = vld_p_q;
        last_p_d = last_p_q;
        data_p_d = data_p_q;
        if (!stall) begin
            vld_p_d[0]  = in_fire;
            last_p_d[0] = in_fire && in_is_last;
            data_p_d[0] = alu_res;
            for (int i = 1; i < C_PIPE_STAGES; i++) begin
                vld_p_d[i]  = vld_p_q[i-1];
                last_p_d[i] = last_p_q[i-1];
                data_p_d[i] = data_p_q[i-1];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        in_cnt_d = in_cnt_q;
        err_d    = err_q;
        mode_d   = mode_q;
        const_d  = const_q;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    mode_d   = ctrl_mode;
                    const_d  = ctrl_constant;
                    total_d  = total_calc;
                    in_cnt_d = '0;
                    err_d    = 1'b0;
                    state_d  = (total_calc == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (in_fire) begin
                    in_cnt_d = in_cnt_q + CW'(1);
                    if (in_is_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_fire && m_axis_tlast) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (in_fire && (s_axis_tlast != in_is_last)) err_d = 1'b1;
    end

    // Control state: reset applies here only.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state_q  <= S_IDLE;
            total_q  <= '0;
            in_cnt_q <= '0;
            err_q    <= 1'b0;
            vld_p_q  <= '0;
            last_p_q <= '0;
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            in_cnt_q <= in_cnt_d;
            err_q    <= err_d;
            vld_p_q  <= vld_p_d;
            last_p_q <= last_p_d;
        end
    end

    // Datapath registers carry no reset; their contents are qualified by the valids.
    always_ff @(posedge aclk) begin
        mode_q   <= mode_d;
        const_q  <= const_d;
        data_p_q <= data_p_d;
    end

endmodule
